// File: rtl/tournament_br_predictor.sv
// tournament_br_predictor
//   Tournament branch direction predictor: a local PHT and a gshare PHT of
//   2-bit saturating counters, arbitrated per branch by a chooser table of
//   2-bit counters, plus a non-speculative global history register.
//   Prediction is purely combinational; training happens on the rising clock
//   edge of a resolved conditional branch.
//   Optional feature macro: BR_PRED_STATS_EN builds the resolved-branch and
//   mispredict counters; without it the stat ports are tied to zero.
module tournament_br_predictor #(
    parameter int IDX_BITS = 6,
    parameter int GHR_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pred_pc,
    output logic                pred_dir,
    output logic                pred_lc_dir,
    output logic                pred_gl_dir,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic                upd_taken,
    input  logic                upd_pred_dir,
    input  logic                upd_lc_dir,
    input  logic                upd_gl_dir,
    input  logic [GHR_BITS-1:0] upd_ghr,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
);

    localparam int ENTRIES = 1 << IDX_BITS;

    // 2-bit counter encodings (br_pred / tn_predictor)
    localparam logic [1:0] WEAKLY_NOT_TAKEN   = 2'b01;
    localparam logic [1:0] USE_LC_PREDICTOR_2 = 2'b01;

    // Saturating +1 (up) / -1 (down) step of a 2-bit counter
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        if (up) begin
            return (cnt == 2'b11) ? cnt : cnt + 2'd1;
        end
        return (cnt == 2'b00) ? cnt : cnt - 2'd1;
    endfunction

    logic [1:0]          lpht_q [ENTRIES];
    logic [1:0]          gpht_q [ENTRIES];
    logic [1:0]          chs_q  [ENTRIES];
    logic [GHR_BITS-1:0] ghr_q;
    logic [GHR_BITS-1:0] ghr_d;

    logic [IDX_BITS-1:0] pred_li;
    logic [IDX_BITS-1:0] pred_gi;
    logic [IDX_BITS-1:0] upd_li;
    logic [IDX_BITS-1:0] upd_gi;
    logic [1:0]          lpht_upd_d;
    logic [1:0]          gpht_upd_d;
    logic [1:0]          chs_upd_d;

    // Prediction side: local/chooser indexed by PC, gshare by PC ^ live GHR
    assign pred_li     = pred_pc[IDX_BITS+1:2];
    assign pred_gi     = pred_li ^ IDX_BITS'(ghr_q);
    assign pred_lc_dir = lpht_q[pred_li][1];
    assign pred_gl_dir = gpht_q[pred_gi][1];
    assign pred_dir    = chs_q[pred_li][1] ? pred_gl_dir : pred_lc_dir;
    assign pred_ghr    = ghr_q;

    // Update side: gshare index uses the history snapshot taken at fetch
    assign upd_li     = upd_pc[IDX_BITS+1:2];
    assign upd_gi     = upd_li ^ IDX_BITS'(upd_ghr);
    assign lpht_upd_d = sat_step(lpht_q[upd_li], upd_taken);
    assign gpht_upd_d = sat_step(gpht_q[upd_gi], upd_taken);
    assign chs_upd_d  = sat_step(chs_q[upd_li], upd_gl_dir == upd_taken);
    assign ghr_d      = GHR_BITS'({ghr_q, upd_taken});

    // Train the three counter tables on each resolved conditional branch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                lpht_q[i] <= WEAKLY_NOT_TAKEN;
                gpht_q[i] <= WEAKLY_NOT_TAKEN;
                chs_q[i]  <= USE_LC_PREDICTOR_2;
            end
        end else if (upd_valid) begin
            lpht_q[upd_li] <= lpht_upd_d;
            gpht_q[upd_gi] <= gpht_upd_d;
            // Chooser only learns when the components disagreed
            if (upd_lc_dir != upd_gl_dir) begin
                chs_q[upd_li] <= chs_upd_d;
            end
        end
    end

    // Shift the resolved outcome into the non-speculative global history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (upd_valid) begin
            ghr_q <= ghr_d;
        end
    end

`ifdef BR_PRED_STATS_EN
    // Saturating +1 on a 32-bit event counter
    function automatic logic [31:0] sat_inc32(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    logic [31:0] br_cnt_q;
    logic [31:0] br_cnt_d;
    logic [31:0] mp_cnt_q;
    logic [31:0] mp_cnt_d;

    // Next-state of the branch and mispredict counters
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (upd_valid) begin
            br_cnt_d = sat_inc32(br_cnt_q);
            if (upd_pred_dir != upd_taken) begin
                mp_cnt_d = sat_inc32(mp_cnt_q);
            end
        end
    end

    // Statistics counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign stat_branches    = br_cnt_q;
    assign stat_mispredicts = mp_cnt_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;

    logic unused_stat_inputs;
    assign unused_stat_inputs = upd_pred_dir;
`endif

    // PC bits outside the index field do not take part in prediction
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                              upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

endmodule
